dm_sba_ctrl: RTL

//  Parametrised system-bus-access engine for the debug module. Converts debugger SBA register

---
 rtl/dm_sba_ctrl.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/dm_sba_ctrl.sv
// dm_sba_ctrl: system-bus-access engine for the debug module.
// Turns debugger sbaddress/sbdata events into single-beat req/gnt/r_valid
// transfers. Handles lane alignment, size and alignment checks, bus errors,
// timeouts and the sticky sberror/sbbusyerror flags.
module dm_sba_ctrl #(
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned BusWidth   = 32,
    parameter int unsigned TimeoutCyc = 1023
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  dmactive_i,

    output logic                  master_req_o,
    output logic [AddrWidth-1:0]  master_add_o,
    output logic                  master_we_o,
    output logic [BusWidth-1:0]   master_wdata_o,
    output logic [BusWidth/8-1:0] master_be_o,
    input  logic                  master_gnt_i,
    input  logic                  master_r_valid_i,
    input  logic                  master_r_err_i,
    input  logic [BusWidth-1:0]   master_r_rdata_i,

    input  logic [AddrWidth-1:0]  sbaddress_i,
    input  logic                  sbaddress_write_valid_i,
    input  logic                  sbreadonaddr_i,
    input  logic                  sbautoincrement_i,
    input  logic [2:0]            sbaccess_i,
    input  logic                  sbreadondata_i,
    input  logic [BusWidth-1:0]   sbdata_i,
    input  logic                  sbdata_read_valid_i,
    input  logic                  sbdata_write_valid_i,
    input  logic                  sberror_clear_i,
    input  logic                  sbbusyerror_clear_i,

    output logic [AddrWidth-1:0]  sbaddress_o,
    output logic [BusWidth-1:0]   sbdata_o,
    output logic                  sbdata_valid_o,
    output logic                  sbbusy_o,
    output logic [2:0]            sberror_o,
    output logic                  sbbusyerror_o
);

    localparam int ByteW = int'(BusWidth / 8);
    localparam int OffW  = $clog2(ByteW);
    localparam int CntW  = (TimeoutCyc > 0) ? $clog2(TimeoutCyc + 1) : 1;
    localparam logic [CntW-1:0] TimeoutLast = (TimeoutCyc > 0) ? CntW'(TimeoutCyc - 1) : '0;

    typedef enum logic [1:0] {
        Idle = 2'd0,
        Req  = 2'd1,
        Wait = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [AddrWidth-1:0] addr_q;
    logic                 we_q;
    logic [2:0]           size_q;
    logic                 autoinc_q;
    logic [BusWidth-1:0]  wdata_q;
    logic [ByteW-1:0]     be_q;
    logic [CntW-1:0]      tcnt_q;
    logic [2:0]           sberror_q;
    logic                 sbbusyerror_q;
    logic [BusWidth-1:0]  sbdata_q;
    logic                 sbdata_valid_q;

    logic                 soft_rst;
    logic                 write_start;
    logic                 read_start;
    logic                 start_req;
    logic                 busy;
    logic                 start_blocked;
    logic [OffW-1:0]      off_new;
    logic [OffW-1:0]      off_q;
    logic                 size_bad;
    logic                 misaligned;
    logic                 timeout_hit;
    logic [ByteW-1:0]     be_new;
    logic [BusWidth-1:0]  wdata_new;
    logic [BusWidth-1:0]  rdata_shift;
    logic [BusWidth-1:0]  rdata_aligned;
    int                   nbytes_new;
    int                   nbytes_q;

    logic                 start_ok;
    logic [2:0]           err_set;
    logic                 busyerr_set;
    logic                 rd_ok;
    logic                 incr;

    assign soft_rst      = rst_i | ~dmactive_i;
    assign write_start   = sbdata_write_valid_i;
    assign read_start    = (sbaddress_write_valid_i & sbreadonaddr_i)
                         | (sbdata_read_valid_i & sbreadondata_i);
    assign start_req     = write_start | read_start;
    assign busy          = (state_q != Idle);
    assign start_blocked = (sberror_q != 3'd0) | sbbusyerror_q;
    assign busyerr_set   = busy & (sbaddress_write_valid_i | start_req);
    assign timeout_hit   = (TimeoutCyc != 0) && (tcnt_q == TimeoutLast);
    assign size_bad      = (sbaccess_i > 3'(OffW));
    assign off_q         = addr_q[OffW-1:0];

    // The access uses a freshly written address when one arrives in the start cycle.
    always_comb begin
        off_new    = sbaddress_write_valid_i ? sbaddress_i[OffW-1:0] : addr_q[OffW-1:0];
        misaligned = 1'b0;
        for (int i = 0; i < OffW; i++) begin
            if ((i < int'(sbaccess_i)) && off_new[i]) begin
                misaligned = 1'b1;
            end
        end
    end

    // Byte enables and write data steered to the lanes of the new access.
    always_comb begin
        nbytes_new = 1 << sbaccess_i;
        be_new     = '0;
        for (int i = 0; i < ByteW; i++) begin
            be_new[i] = (i >= int'(off_new)) && (i < int'(off_new) + nbytes_new);
        end
        wdata_new = sbdata_i << {off_new, 3'b000};
    end

    // Read data moved down from its lane and zero-extended to the access size.
    always_comb begin
        nbytes_q      = 1 << size_q;
        rdata_shift   = master_r_rdata_i >> {off_q, 3'b000};
        rdata_aligned = '0;
        for (int i = 0; i < ByteW; i++) begin
            if (i < nbytes_q) begin
                rdata_aligned[8*i +: 8] = rdata_shift[8*i +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (soft_rst) begin
            state_q <= Idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus the per-cycle events it decides (start, error, completion).
    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        err_set  = 3'd0;
        rd_ok    = 1'b0;
        incr     = 1'b0;
        case (state_q)
            Idle: begin
                if (start_req && !start_blocked) begin
                    if (size_bad) begin
                        err_set = 3'd4;
                    end else if (misaligned) begin
                        err_set = 3'd3;
                    end else begin
                        start_ok = 1'b1;
                        state_d  = Req;
                    end
                end
            end
            Req: begin
                if (timeout_hit) begin
                    err_set = 3'd1;
                    state_d = Idle;
                end else if (master_gnt_i) begin
                    state_d = Wait;
                end
            end
            Wait: begin
                if (master_r_valid_i) begin
                    state_d = Idle;
                    if (master_r_err_i) begin
                        err_set = 3'd2;
                    end else begin
                        incr  = autoinc_q;
                        rd_ok = ~we_q;
                    end
                end else if (timeout_hit) begin
                    err_set = 3'd1;
                    state_d = Idle;
                end
            end
            default: state_d = Idle;
        endcase
    end

    // Outputs decoded from the current state and the transfer registers.
    always_comb begin
        master_req_o   = (state_q == Req);
        sbbusy_o       = busy;
        master_add_o   = addr_q;
        master_we_o    = we_q;
        master_wdata_o = wdata_q;
        master_be_o    = be_q;
        sbaddress_o    = addr_q;
        sbdata_o       = sbdata_q;
        sbdata_valid_o = sbdata_valid_q;
        sberror_o      = sberror_q;
        sbbusyerror_o  = sbbusyerror_q;
    end

    // Address, transfer attributes, timeout counter, read data and sticky errors.
    always_ff @(posedge clk_i) begin
        if (soft_rst) begin
            addr_q         <= '0;
            we_q           <= 1'b0;
            size_q         <= 3'd0;
            autoinc_q      <= 1'b0;
            wdata_q        <= '0;
            be_q           <= '0;
            tcnt_q         <= '0;
            sberror_q      <= 3'd0;
            sbbusyerror_q  <= 1'b0;
            sbdata_q       <= '0;
            sbdata_valid_q <= 1'b0;
        end else begin
            if (!busy && sbaddress_write_valid_i) begin
                addr_q <= sbaddress_i;
            end else if (incr) begin
                addr_q <= addr_q + (AddrWidth'(1) << size_q);
            end

            if (start_ok) begin
                we_q      <= write_start;
                size_q    <= sbaccess_i;
                autoinc_q <= sbautoincrement_i;
                wdata_q   <= wdata_new;
                be_q      <= be_new;
            end

            if (start_ok) begin
                tcnt_q <= '0;
            end else if (busy) begin
                tcnt_q <= tcnt_q + 1'b1;
            end

            sbdata_valid_q <= rd_ok;
            if (rd_ok) begin
                sbdata_q <= rdata_aligned;
            end

            if (err_set != 3'd0) begin
                sberror_q <= err_set;
            end else if (sberror_clear_i) begin
                sberror_q <= 3'd0;
            end

            if (busyerr_set) begin
                sbbusyerror_q <= 1'b1;
            end else if (sbbusyerror_clear_i) begin
                sbbusyerror_q <= 1'b0;
            end
        end
    end

endmodule
